// File: rtl/sram_fail_reporter.sv
// Reports SRAM tester results as ASCII lines over a valid/ready byte stream:
// "PASS\r\n" per clean pass, or one snapshot line of the first miscompare followed by a halt.
//
// state     | meaning
// IDLE      | waiting for a pass completion or a miscompare
// SEND_PASS | emitting "PASS\r\n"
// SEND_FAIL | emitting the captured failure line
// HALT      | failure reported; silent until reset
module sram_fail_reporter #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 test_pass,
   input  logic                 test_done,
   input  logic [2:0]           pattern_state,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_BITS-1:0] prev_expected_data,
   input  logic [DATA_BITS-1:0] prev_read_data,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 fail_latched
);
   localparam int NA       = (ADDR_BITS + 3) / 4;
   localparam int ND       = (DATA_BITS + 3) / 4;
   localparam int A_POS    = 4;
   localparam int E_POS    = A_POS + NA + 1;
   localparam int R_POS    = E_POS + ND + 1;
   localparam int CR_POS   = R_POS + ND;
   localparam int FAIL_LEN = CR_POS + 2;
   localparam int PASS_LEN = 6;
   localparam int IDX_W    = $clog2(FAIL_LEN);

   typedef enum logic [1:0] {IDLE, SEND_PASS, SEND_FAIL, HALT} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              pass_q;
   logic              done_q;
   logic              pass_pending;
   logic [2:0]        snap_pat;
   logic [4*NA-1:0]   snap_addr;
   logic [4*ND-1:0]   snap_exp;
   logic [4*ND-1:0]   snap_rd;

   logic              fail_ev;
   logic              done_ev;
   logic              fail_new;
   logic [IDX_W-1:0]  last_idx;

   assign fail_ev  = pass_q & ~test_pass;
   assign done_ev  = ~done_q & test_done & test_pass;
   assign fail_new = fail_ev & ~fail_latched;
   assign last_idx = (state == SEND_FAIL) ? IDX_W'(FAIL_LEN - 1) : IDX_W'(PASS_LEN - 1);

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] line_byte(input logic [IDX_W-1:0] i, input logic is_fail);
      int p;
      logic [7:0] b;
      p = int'(i);
      b = 8'h20;
      if (!is_fail) begin
         case (p)
            0:       b = 8'h50;
            1:       b = 8'h41;
            2, 3:    b = 8'h53;
            4:       b = 8'h0D;
            default: b = 8'h0A;
         endcase
      end else if (p == 0) begin
         b = 8'h46;
      end else if (p == 2) begin
         b = 8'h30 + {5'd0, snap_pat};
      end else if (p >= A_POS && p < A_POS + NA) begin
         b = hex_char(4'(snap_addr >> (4 * (A_POS + NA - 1 - p))));
      end else if (p >= E_POS && p < E_POS + ND) begin
         b = hex_char(4'(snap_exp >> (4 * (E_POS + ND - 1 - p))));
      end else if (p >= R_POS && p < R_POS + ND) begin
         b = hex_char(4'(snap_rd >> (4 * (R_POS + ND - 1 - p))));
      end else if (p == CR_POS) begin
         b = 8'h0D;
      end else if (p == CR_POS + 1) begin
         b = 8'h0A;
      end
      return b;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         pass_q       <= 1'b1;
         done_q       <= 1'b0;
         pass_pending <= 1'b0;
         snap_pat     <= '0;
         snap_addr    <= '0;
         snap_exp     <= '0;
         snap_rd      <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         busy         <= 1'b0;
         fail_latched <= 1'b0;
      end else begin
         pass_q <= test_pass;
         done_q <= test_done;
         if (fail_new) begin
            snap_pat     <= pattern_state;
            snap_addr    <= (4*NA)'(addr);
            snap_exp     <= (4*ND)'(prev_expected_data);
            snap_rd      <= (4*ND)'(prev_read_data);
            fail_latched <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (fail_new) begin
                  state <= SEND_FAIL;
                  busy  <= 1'b1;
                  idx   <= '0;
               end else if (done_ev || pass_pending) begin
                  state        <= SEND_PASS;
                  busy         <= 1'b1;
                  idx          <= '0;
                  pass_pending <= 1'b0;
               end
            end
            SEND_PASS, SEND_FAIL: begin
               if (done_ev && !fail_ev) pass_pending <= 1'b1;
               // first byte is loaded one cycle after entering the state
               if (!tx_valid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= line_byte(idx, state == SEND_FAIL);
               end else if (tx_ready) begin
                  if (idx == last_idx) begin
                     tx_valid <= 1'b0;
                     idx      <= '0;
                     if (state == SEND_FAIL) begin
                        state <= HALT;
                        busy  <= 1'b0;
                     end else if (fail_latched || fail_new) begin
                        state <= SEND_FAIL;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     idx     <= idx + IDX_W'(1);
                     tx_data <= line_byte(idx + IDX_W'(1), state == SEND_FAIL);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_fail_reporter.sv
// Directed bench for sram_fail_reporter: expected byte streams are built as strings from the
// reported values and checked byte-by-byte on every transfer, plus literal line/latency checks.
module tb_sram_fail_reporter;
   localparam int AB = 20;
   localparam int DB = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          test_pass = 1'b1;
   logic          test_done = 1'b0;
   logic [2:0]    pattern_state = '0;
   logic [AB-1:0] addr = '0;
   logic [DB-1:0] prev_expected_data = '0;
   logic [DB-1:0] prev_read_data = '0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic          fail_latched;

   int            n_tests = 0;
   int            n_fail = 0;
   int            n_xfer = 0;
   byte unsigned  exp_q[$];
   string         rx_line = "";
   bit            ready_toggle = 1'b0;
   bit            ready_level = 1'b0;
   int            rphase = 0;
   bit            hold_v = 1'b0;
   logic [7:0]    hold_d = '0;

   always #5 clk = ~clk;

   sram_fail_reporter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .test_pass          (test_pass),
      .test_done          (test_done),
      .pattern_state      (pattern_state),
      .addr               (addr),
      .prev_expected_data (prev_expected_data),
      .prev_read_data     (prev_read_data),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .busy               (busy),
      .fail_latched       (fail_latched)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_str(input string name, input string act, input string req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got \"%s\" (len %0d), expected \"%s\" (len %0d)",
                  name, act, act.len(), req, req.len());
      end
   endtask

   function automatic string hexs(input logic [31:0] v, input int nd);
      string digits;
      string s;
      digits = "0123456789ABCDEF";
      s = "";
      for (int k = nd - 1; k >= 0; k--) s = {s, digits.substr(int'((v >> (4 * k)) & 32'hF), int'((v >> (4 * k)) & 32'hF))};
      return s;
   endfunction

   task automatic expect_line(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // Transfer monitor: every accepted byte must be the next expected one; stalls must hold data.
   always @(negedge clk) begin
      if (reset_n && tx_valid) begin
         if (hold_v) check("stall_hold", {24'd0, tx_data}, {24'd0, hold_d});
         check("busy_while_valid", {31'd0, busy}, 32'd1);
         if (tx_ready) begin
            n_xfer++;
            rx_line = $sformatf("%s%c", rx_line, tx_data);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
            end else begin
               check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            hold_v = 1'b0;
         end else begin
            hold_v = 1'b1;
            hold_d = tx_data;
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (ready_toggle) begin
         tx_ready = (rphase == 0);
         rphase = (rphase + 1) % 3;
      end else begin
         tx_ready = ready_level;
         rphase = 0;
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      test_pass = 1'b1;
      test_done = 1'b0;
      repeat (2) @(posedge clk);
      exp_q.delete();
      rx_line = "";
      n_xfer = 0;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic drop_pass(input logic [2:0] p, input logic [AB-1:0] a,
                            input logic [DB-1:0] e, input logic [DB-1:0] r);
      @(posedge clk);
      #1;
      pattern_state = p;
      addr = a;
      prev_expected_data = e;
      prev_read_data = r;
      test_pass = 1'b0;
      expect_line({"F ", hexs(32'(p), 1), " ", hexs(32'(a), 5), " ",
                   hexs(32'(e), 4), " ", hexs(32'(r), 4), "\r\n"});
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int c;
      c = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      while ((busy || tx_valid || exp_q.size() != 0) && c < max_cyc) begin
         @(posedge clk);
         #1;
         c++;
      end
      check({name, "_in_time"}, 32'(c < max_cyc), 32'd1);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset_n = 1'b0;
      #12;
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fail_latched", {31'd0, fail_latched}, 32'd0);
      do_reset();

      // 1: single pass line, with latency pinned
      ready_level = 1'b1;
      @(posedge clk);
      #1 test_done = 1'b1;
      expect_line("PASS\r\n");
      @(posedge clk);
      #1 test_done = 1'b0;
      check("lat_edge_n_valid", {31'd0, tx_valid}, 32'd0);
      check("lat_edge_n_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check("lat_edge_n1_valid", {31'd0, tx_valid}, 32'd1);
      check("lat_edge_n1_data", {24'd0, tx_data}, 32'h50);
      wait_idle("pass1", 100);
      check_str("pass1_line", rx_line, "PASS\r\n");
      check("pass1_fail_latched", {31'd0, fail_latched}, 32'd0);
      check("pass1_valid_low", {31'd0, tx_valid}, 32'd0);

      // 2: failure line, then halt
      rx_line = "";
      drop_pass(3'd3, 20'h0ABCD, 16'h5555, 16'h5554);
      @(posedge clk);
      #1 check("fail2_latched_now", {31'd0, fail_latched}, 32'd1);
      wait_idle("fail2", 200);
      check_str("fail2_line", rx_line, "F 3 0ABCD 5555 5554\r\n");
      check("fail2_latched", {31'd0, fail_latched}, 32'd1);
      test_pass = 1'b1;
      repeat (2) @(posedge clk);
      #1 test_done = 1'b1;
      @(posedge clk);
      #1 test_done = 1'b0;
      test_pass = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("halt_silent_valid", {31'd0, tx_valid}, 32'd0);
      check("halt_busy", {31'd0, busy}, 32'd0);

      // 3: same failure with a 1-on / 2-off ready pattern
      do_reset();
      ready_toggle = 1'b1;
      drop_pass(3'd3, 20'h0ABCD, 16'h5555, 16'h5554);
      wait_idle("fail3", 300);
      check_str("fail3_line", rx_line, "F 3 0ABCD 5555 5554\r\n");
      ready_toggle = 1'b0;

      // 4: failure arrives mid-PASS; address changes after the fail cycle
      do_reset();
      ready_level = 1'b1;
      @(posedge clk);
      #1 test_done = 1'b1;
      expect_line("PASS\r\n");
      @(posedge clk);
      #1 test_done = 1'b0;
      @(posedge clk);
      drop_pass(3'd5, 20'h12345, 16'hBEEF, 16'hBEAF);
      @(posedge clk);
      #1;
      addr = 20'hFFFFF;
      prev_expected_data = 16'h0000;
      prev_read_data = 16'hFFFF;
      pattern_state = 3'd1;
      check("fail4_busy_mid", {31'd0, busy}, 32'd1);
      check("fail4_latched_mid", {31'd0, fail_latched}, 32'd1);
      wait_idle("fail4", 300);
      check_str("fail4_lines", rx_line, "PASS\r\nF 5 12345 BEEF BEAF\r\n");

      // 5: reset after the 7th fail byte abandons the line
      do_reset();
      ready_level = 1'b1;
      drop_pass(3'd3, 20'h0ABCD, 16'h5555, 16'h5554);
      begin
         int c;
         c = 0;
         while (n_xfer < 7 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
         end
         check("rst5_reached_7", 32'(n_xfer), 32'd7);
      end
      reset_n = 1'b0;
      #1;
      check("rst5_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst5_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst5_busy", {31'd0, busy}, 32'd0);
      check("rst5_fail_latched", {31'd0, fail_latched}, 32'd0);
      check_str("rst5_partial", rx_line, "F 3 0AB");
      exp_q.delete();
      test_pass = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("rst5_silent_valid", {31'd0, tx_valid}, 32'd0);
      check("rst5_silent_busy", {31'd0, busy}, 32'd0);
      check_str("rst5_no_bytes", rx_line, "F 3 0AB");

      // 6: fail and done presented together: only the failure line, ever
      do_reset();
      ready_level = 1'b1;
      @(posedge clk);
      #1;
      pattern_state = 3'd6;
      addr = 20'h00F0F;
      prev_expected_data = 16'h0001;
      prev_read_data = 16'h8001;
      test_pass = 1'b0;
      test_done = 1'b1;
      expect_line("F 6 00F0F 0001 8001\r\n");
      wait_idle("fail6", 200);
      test_pass = 1'b1;
      repeat (3) @(posedge clk);
      #1 test_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 test_done = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_str("fail6_line_only", rx_line, "F 6 00F0F 0001 8001\r\n");
      check("fail6_latched", {31'd0, fail_latched}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
